// File: rtl/legv8_multicycle_control_pkg.sv
// legv8_multicycle_control_pkg: shared state encoding, opcode constants and instruction classes
// for the LEGv8 multicycle controller.
package legv8_multicycle_control_pkg;
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [2:0] {C_ILLEGAL, C_LDUR, C_STUR, C_CBZ, C_B, C_RTYPE} iclass_t;
    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_CBZ = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
endpackage

// File: rtl/legv8_multicycle_control_decoder.sv
// legv8_main_decoder: combinational opcode classifier producing the static ALU controls.
module legv8_main_decoder
    import legv8_multicycle_control_pkg::*;
(
    input  logic [10:0] opcode_i,
    output logic [2:0]  iclass_o,
    output logic [1:0]  alu_op_o,
    output logic        alu_src_o,
    output logic        reg2loc_o
);
    iclass_t cls;
    assign cls = opcode_i == OP_LDUR ? C_LDUR :
                 opcode_i == OP_STUR ? C_STUR :
                 opcode_i[10:3] == OP_CBZ ? C_CBZ :
                 opcode_i[10:5] == OP_B ? C_B :
                 opcode_i inside {OP_ADD, OP_SUB, OP_AND, OP_ORR} ? C_RTYPE : C_ILLEGAL;
    assign iclass_o  = cls;
    assign alu_op_o  = cls == C_CBZ ? ALUOP_CBZ : cls == C_RTYPE ? ALUOP_R : ALUOP_MEM;
    assign alu_src_o = cls inside {C_LDUR, C_STUR};
    assign reg2loc_o = cls inside {C_STUR, C_CBZ};
endmodule

// File: rtl/legv8_multicycle_control.sv
// legv8_multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer for a LEGv8 subset.
// Strobes are decoded from the registered state; ALU controls are captured in DECODE and held to WB.
module legv8_multicycle_control
    import legv8_multicycle_control_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [1:0]  ALUOp,
    output logic [10:0] Opcode_field,
    input  logic        Zero,
    output logic        Reg2Loc,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        PCWrite,
    output logic        PCBranch,
    input  logic        mem_ready,
    output logic        illegal,
    output logic        busy
);
    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [1:0]  alu_op_q, alu_op_d;
    logic        alu_src_q, alu_src_d;
    logic        reg2loc_q, reg2loc_d;
    logic [2:0]  cls_w;
    logic [1:0]  dec_alu_op;
    logic        dec_alu_src, dec_reg2loc;
    logic        unused_ir;
    iclass_t     cls;

    legv8_main_decoder u_dec (
        .opcode_i  (ir_q[31:21]),
        .iclass_o  (cls_w),
        .alu_op_o  (dec_alu_op),
        .alu_src_o (dec_alu_src),
        .reg2loc_o (dec_reg2loc)
    );

    assign cls       = iclass_t'(cls_w);
    assign unused_ir = ^ir_q[20:0];

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        alu_op_d  = alu_op_q;
        alu_src_d = alu_src_q;
        reg2loc_d = reg2loc_q;
        case (state_q)
            S_FETCH: begin
                ir_d    = instr_valid ? instr : ir_q;
                state_d = instr_valid ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                state_d   = cls == C_ILLEGAL ? S_FETCH : S_EXEC;
                alu_op_d  = dec_alu_op;
                alu_src_d = dec_alu_src;
                reg2loc_d = dec_reg2loc;
            end
            S_EXEC:  state_d = cls inside {C_LDUR, C_STUR} ? S_MEM : cls == C_RTYPE ? S_WB : S_FETCH;
            S_MEM:   state_d = !mem_ready ? S_MEM : cls == C_LDUR ? S_WB : S_FETCH;
            default: state_d = S_FETCH;
        endcase
        // Controls return to zero whenever the instruction retires or is dropped.
        if (state_d == S_FETCH) begin
            alu_op_d  = '0;
            alu_src_d = 1'b0;
            reg2loc_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            alu_op_q  <= '0;
            alu_src_q <= 1'b0;
            reg2loc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            alu_op_q  <= alu_op_d;
            alu_src_q <= alu_src_d;
            reg2loc_q <= reg2loc_d;
        end
    end

    assign instr_ready  = state_q == S_FETCH;
    assign busy         = state_q != S_FETCH;
    assign Opcode_field = ir_q[31:21];
    assign ALUOp        = alu_op_q;
    assign ALUSrc       = alu_src_q;
    assign Reg2Loc      = reg2loc_q;
    assign illegal      = state_q == S_DECODE && cls == C_ILLEGAL;
    assign MemRead      = state_q == S_MEM && cls == C_LDUR;
    assign MemWrite     = state_q == S_MEM && cls == C_STUR;
    assign RegWrite     = state_q == S_WB;
    assign MemtoReg     = state_q == S_WB && cls == C_LDUR;
    assign PCBranch     = state_q == S_EXEC && (cls == C_B || (cls == C_CBZ && Zero));
    assign PCWrite      = state_q == S_WB ||
                          (state_q == S_MEM && cls == C_STUR && mem_ready) ||
                          (state_q == S_EXEC && cls == C_CBZ && !Zero);
endmodule
